// File: rtl/pc_redirect_pkg.sv
// Shared definitions for the PC redirect unit: FSM state encoding, the
// PR return-address offset, the reset address and the return-address helper.
package pc_redirect_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DS_WAIT = 2'd1,
        ST_REDIR   = 2'd2
    } state_e;

    localparam logic [31:0] PR_RET_OFFSET = 32'd4;
    localparam logic [31:0] RESET_ADDR    = 32'h0000_0000;

    // Return address saved into PR; 32-bit addition wraps modulo 2^32.
    function automatic logic [31:0] pr_ret_addr(input logic [31:0] pc);
        return pc + PR_RET_OFFSET;
    endfunction

endpackage

// File: rtl/pc_redirect_if.sv
// Branch-resolution / fetch-redirect bundle for pc_redirect.
// master: the side that produces branch results and consumes redirects.
// slave : the pc_redirect unit itself.
interface pc_redirect_if;
    logic        br_valid;
    logic        br_taken;
    logic        br_delayslot;
    logic        br_write_pr;
    logic [31:0] br_target;
    logic [31:0] br_pc;
    logic        ds_valid;
    logic        ds_branch;
    logic        fetch_ready;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        flush;
    logic        pr_we;
    logic [31:0] pr_wdata;
    logic        busy;
    logic        slot_illegal;

    modport master (
        output br_valid, br_taken, br_delayslot, br_write_pr, br_target, br_pc,
               ds_valid, ds_branch, fetch_ready,
        input  redir_valid, redir_pc, flush, pr_we, pr_wdata, busy, slot_illegal
    );

    modport slave (
        input  br_valid, br_taken, br_delayslot, br_write_pr, br_target, br_pc,
               ds_valid, ds_branch, fetch_ready,
        output redir_valid, redir_pc, flush, pr_we, pr_wdata, busy, slot_illegal
    );
endinterface

// File: rtl/pc_redirect.sv
// PC redirect unit: turns resolved taken branches into a fetch redirect,
// waiting for the delay-slot instruction when the branch has one, and
// produces the PR (return address) write for call-type branches.
// Optional feature: define PC_REDIRECT_PERF_EN to add perf_taken_cnt, a
// wrapping count of completed redirect handshakes.
module pc_redirect
    import pc_redirect_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    pc_redirect_if.slave  bus
`ifdef PC_REDIRECT_PERF_EN
    ,
    output logic [31:0]   perf_taken_cnt
`endif
);

    state_e      state_r;
    state_e      state_nxt_s;
    logic [31:0] target_r;
    logic [31:0] target_nxt_s;
    logic        flush_r;
    logic        flush_nxt_s;
    logic        slot_illegal_r;
    logic        slot_illegal_nxt_s;
    logic        pr_we_r;
    logic        pr_we_nxt_s;
    logic [31:0] pr_wdata_r;
    logic [31:0] pr_wdata_nxt_s;
    logic        hs_done_s;

    // Next-state and next-output decode; branches are only looked at in IDLE
    // because upstream stalls new branches while busy is high.
    always_comb begin
        state_nxt_s        = state_r;
        target_nxt_s       = target_r;
        flush_nxt_s        = 1'b0;
        slot_illegal_nxt_s = 1'b0;
        pr_we_nxt_s        = 1'b0;
        pr_wdata_nxt_s     = pr_wdata_r;
        hs_done_s          = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.br_valid) begin
                    if (bus.br_write_pr) begin
                        pr_we_nxt_s    = 1'b1;
                        pr_wdata_nxt_s = pr_ret_addr(bus.br_pc);
                    end else begin
                        pr_we_nxt_s    = 1'b0;
                    end
                    if (bus.br_taken) begin
                        target_nxt_s = bus.br_target;
                        if (bus.br_delayslot) begin
                            state_nxt_s = ST_DS_WAIT;
                        end else begin
                            state_nxt_s = ST_REDIR;
                            flush_nxt_s = 1'b1;
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DS_WAIT: begin
                if (bus.ds_valid) begin
                    if (bus.ds_branch) begin
                        // Branch in a delay slot: drop the redirect, report it.
                        state_nxt_s        = ST_IDLE;
                        slot_illegal_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_REDIR;
                        flush_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_DS_WAIT;
                end
            end
            ST_REDIR: begin
                if (bus.fetch_ready) begin
                    state_nxt_s = ST_IDLE;
                    hs_done_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_REDIR;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and pending target register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            target_r <= RESET_ADDR;
        end else begin
            state_r  <= state_nxt_s;
            target_r <= target_nxt_s;
        end
    end

    // Registered pulse outputs and PR write data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_r        <= 1'b0;
            slot_illegal_r <= 1'b0;
            pr_we_r        <= 1'b0;
            pr_wdata_r     <= RESET_ADDR;
        end else begin
            flush_r        <= flush_nxt_s;
            slot_illegal_r <= slot_illegal_nxt_s;
            pr_we_r        <= pr_we_nxt_s;
            pr_wdata_r     <= pr_wdata_nxt_s;
        end
    end

`ifdef PC_REDIRECT_PERF_EN
    logic [31:0] perf_cnt_r;

    // Count completed redirect handshakes; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt_r <= 32'd0;
        end else if (hs_done_s) begin
            perf_cnt_r <= perf_cnt_r + 32'd1;
        end else begin
            perf_cnt_r <= perf_cnt_r;
        end
    end

    assign perf_taken_cnt = perf_cnt_r;
`endif

    // redir_pc is driven straight from the held target so it cannot move
    // while the redirect is pending.
    assign bus.redir_valid  = (state_r == ST_REDIR);
    assign bus.redir_pc     = target_r;
    assign bus.busy         = (state_r != ST_IDLE);
    assign bus.flush        = flush_r;
    assign bus.slot_illegal = slot_illegal_r;
    assign bus.pr_we        = pr_we_r;
    assign bus.pr_wdata     = pr_wdata_r;

endmodule

// File: tb/tb_pc_redirect.sv
// Self-checking bench for pc_redirect: directed scenarios plus randomized
// traffic checked cycle by cycle against a transaction-level reference model.
module tb_pc_redirect;

    logic        clk;
    logic        rst_n;
    int          n_tests;
    int          n_fail;
    pc_redirect_if bus ();

`ifdef PC_REDIRECT_PERF_EN
    logic [31:0] perf_cnt;
`endif

    pc_redirect dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef PC_REDIRECT_PERF_EN
        ,
        .perf_taken_cnt (perf_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: "holding a target" and "still waiting for the slot".
    bit          m_pending;
    bit          m_wait_slot;
    logic [31:0] m_target;
    bit          m_flush;
    bit          m_slot;
    bit          m_pr_we;
    logic [31:0] m_pr_wdata;
    int          m_done;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pending   = 1'b0;
        m_wait_slot = 1'b0;
        m_target    = 32'h0;
        m_flush     = 1'b0;
        m_slot      = 1'b0;
        m_pr_we     = 1'b0;
        m_pr_wdata  = 32'h0;
    endtask

    task automatic compare_all();
        bit exp_rv;
        exp_rv = m_pending && !m_wait_slot;
        check_eq("busy", {31'd0, bus.busy}, {31'd0, m_pending});
        check_eq("redir_valid", {31'd0, bus.redir_valid}, {31'd0, exp_rv});
        if (exp_rv) check_eq("redir_pc", bus.redir_pc, m_target);
        check_eq("flush", {31'd0, bus.flush}, {31'd0, m_flush});
        check_eq("slot_illegal", {31'd0, bus.slot_illegal}, {31'd0, m_slot});
        check_eq("pr_we", {31'd0, bus.pr_we}, {31'd0, m_pr_we});
        if (m_pr_we) check_eq("pr_wdata", bus.pr_wdata, m_pr_wdata);
    endtask

    // One clock: snapshot inputs, advance the model at the edge, compare #1 later.
    task automatic step();
        bit          bv, bt, bd, bw, dv, db, fr;
        logic [31:0] tg, pc;
        bv = bus.br_valid; bt = bus.br_taken; bd = bus.br_delayslot; bw = bus.br_write_pr;
        dv = bus.ds_valid; db = bus.ds_branch; fr = bus.fetch_ready;
        tg = bus.br_target; pc = bus.br_pc;
        @(posedge clk);
        m_flush = 1'b0;
        m_slot  = 1'b0;
        m_pr_we = 1'b0;
        if (!m_pending) begin
            if (bv && bw) begin
                m_pr_we    = 1'b1;
                m_pr_wdata = pc + 32'd4;
            end
            if (bv && bt) begin
                m_pending   = 1'b1;
                m_target    = tg;
                m_wait_slot = bd;
                m_flush     = !bd;
            end
        end else if (m_wait_slot) begin
            if (dv && db) begin
                m_pending   = 1'b0;
                m_wait_slot = 1'b0;
                m_slot      = 1'b1;
            end else if (dv) begin
                m_wait_slot = 1'b0;
                m_flush     = 1'b1;
            end
        end else if (fr) begin
            m_pending = 1'b0;
            m_done++;
        end
        #1;
        compare_all();
    endtask

    task automatic clear_inputs();
        bus.br_valid = 1'b0; bus.br_taken = 1'b0; bus.br_delayslot = 1'b0;
        bus.br_write_pr = 1'b0; bus.br_target = 32'h0; bus.br_pc = 32'h0;
        bus.ds_valid = 1'b0; bus.ds_branch = 1'b0; bus.fetch_ready = 1'b0;
    endtask

    task automatic send_br(input bit taken, input bit ds, input bit wpr,
                           input logic [31:0] tgt, input logic [31:0] pc);
        bus.br_valid = 1'b1; bus.br_taken = taken; bus.br_delayslot = ds;
        bus.br_write_pr = wpr; bus.br_target = tgt; bus.br_pc = pc;
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear without a clock edge.
    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check_eq("rst_redir_pc", bus.redir_pc, 32'h0);
        check_eq("rst_pr_wdata", bus.pr_wdata, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_done  = 0;
        clear_inputs();
        rst_n = 1'b1;
        #2;
        apply_reset();

        // Delay-slot branch: redirect one cycle after the slot issues.
        send_br(1'b1, 1'b1, 1'b0, 32'h8C00_1000, 32'h8C00_0000);
        step();
        bus.br_valid = 1'b0;
        step();
        bus.ds_valid = 1'b1; bus.fetch_ready = 1'b1;
        step();
        bus.ds_valid = 1'b0;
        check_eq("bra_flush", {31'd0, bus.flush}, 32'd1);
        check_eq("bra_redir_pc", bus.redir_pc, 32'h8C00_1000);
        step();
        check_eq("bra_idle", {31'd0, bus.busy}, 32'd0);

        // Call with delay slot: PR written the next cycle.
        send_br(1'b1, 1'b1, 1'b1, 32'h8C00_2000, 32'h8C00_0010);
        step();
        clear_inputs();
        check_eq("bsr_pr_wdata", bus.pr_wdata, 32'h8C00_0014);
        bus.ds_valid = 1'b1;
        step();
        bus.ds_valid = 1'b0; bus.fetch_ready = 1'b1;
        step();
        bus.fetch_ready = 1'b0;

        // Fetch stalls three cycles: redirect held, flush only on the first.
        send_br(1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h0000_0100);
        step();
        clear_inputs();
        check_eq("stall_flush0", {31'd0, bus.flush}, 32'd1);
        step();
        step();
        check_eq("stall_flush2", {31'd0, bus.flush}, 32'd0);
        check_eq("stall_pc", bus.redir_pc, 32'h1234_5678);
        bus.fetch_ready = 1'b1;
        step();
        check_eq("stall_done", {31'd0, bus.redir_valid}, 32'd0);
        // Back-to-back acceptance right after the handshake.
        send_br(1'b1, 1'b0, 1'b0, 32'hABCD_0000, 32'h0000_0200);
        step();
        clear_inputs();
        check_eq("b2b_valid", {31'd0, bus.redir_valid}, 32'd1);
        bus.fetch_ready = 1'b1;
        step();
        clear_inputs();

        // Branch in delay slot: illegal pulse, redirect dropped.
        send_br(1'b1, 1'b1, 1'b0, 32'h5555_0000, 32'h0000_0300);
        step();
        clear_inputs();
        bus.ds_valid = 1'b1; bus.ds_branch = 1'b1;
        step();
        clear_inputs();
        check_eq("ill_pulse", {31'd0, bus.slot_illegal}, 32'd1);
        step();

        // Reset while redirecting: nothing resurfaces after release.
        send_br(1'b1, 1'b0, 1'b0, 32'h7777_0000, 32'h0000_0400);
        step();
        clear_inputs();
        apply_reset();
        bus.fetch_ready = 1'b1;
        repeat (3) step();
        // Return-address wrap.
        send_br(1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFC);
        step();
        clear_inputs();
        check_eq("wrap_pr_wdata", bus.pr_wdata, 32'h0);

`ifdef PC_REDIRECT_PERF_EN
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            send_br(1'b1, 1'b0, 1'b0, 32'h100 * k, 32'h0);
            bus.fetch_ready = 1'b1;
            step();
            bus.br_valid = 1'b0;
            step();
        end
        for (int k = 0; k < 2; k++) begin
            send_br(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            step();
        end
        clear_inputs();
        step();
        check_eq("perf_cnt", perf_cnt, 32'd5);
`endif

        // Randomized traffic, including branches offered while busy.
        for (int i = 0; i < 600; i++) begin
            bus.br_valid     = ($urandom_range(0, 99) < 40);
            bus.br_taken     = ($urandom_range(0, 99) < 60);
            bus.br_delayslot = ($urandom_range(0, 99) < 50);
            bus.br_write_pr  = ($urandom_range(0, 99) < 30);
            bus.br_target    = $urandom;
            bus.br_pc        = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            bus.ds_valid     = ($urandom_range(0, 99) < 40);
            bus.ds_branch    = ($urandom_range(0, 99) < 20);
            bus.fetch_ready  = ($urandom_range(0, 99) < 50);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_redirect.md
PC_REDIRECT -- requirements
Module: pc_redirect

Interface
REQ-001 clk  in  1  core clock; all state on rising edge.
REQ-002 rst_n  in  1  asynchronous active-low reset.
REQ-003 br_valid  in  1  branch resolution result valid this cycle.
REQ-004 br_taken, br_delayslot, br_write_pr  in  1 each  branch outcome flags.
REQ-005 br_target  in  32  resolved branch target address.
REQ-006 br_pc  in  32  address of the resolving branch instruction.
REQ-007 ds_valid  in  1  delay-slot instruction issued this cycle.
REQ-008 ds_branch  in  1  issued delay-slot instruction is itself a branch.
REQ-009 fetch_ready  in  1  fetch accepts redirect this cycle.
REQ-010 redir_valid  out  1  redirect request to fetch.
REQ-011 redir_pc  out  32  redirect address, stable while redir_valid high.
REQ-012 flush  out  1  one-cycle pulse killing wrong-path instructions younger than the branch or delay slot.
REQ-013 pr_we / pr_wdata  out  1 / 32  PR write strobe and return address.
REQ-014 busy  out  1  redirect pending; upstream holds new branches.
REQ-015 slot_illegal  out  1  one-cycle pulse, branch found in delay slot.

Function
REQ-016 States: IDLE, DS_WAIT, REDIR; encoding free.
REQ-017 IDLE, br_valid & br_taken & !br_delayslot: latch br_target, next cycle REDIR with flush=1 for that first REDIR cycle only.
REQ-018 IDLE, br_valid & br_taken & br_delayslot: latch br_target, go DS_WAIT; no flush.
REQ-019 IDLE, br_valid & !br_taken: state unchanged, no redirect, no flush.
REQ-020 DS_WAIT, ds_valid & !ds_branch: next cycle REDIR, flush=1 for one cycle.
REQ-021 DS_WAIT, ds_valid & ds_branch: next cycle slot_illegal=1 one cycle, pending redirect dropped, go IDLE, no flush.
REQ-022 REDIR: redir_valid=1, redir_pc=latched target; on redir_valid & fetch_ready go IDLE next cycle.
REQ-023 Handshake: redir_valid never deasserts without fetch_ready; redir_pc constant while pending.
REQ-024 busy = (state != IDLE), combinational from state.
REQ-025 br_valid while busy: ignored, no state/PR effect (upstream stall contract).
REQ-026 br_valid & br_write_pr in IDLE: pr_we=1 next cycle for one cycle, pr_wdata = br_pc + 4, modulo 2^32 (0xFFFFFFFC -> 0x00000000), independent of br_taken.
REQ-027 Minimum latency br_valid -> redir_valid: 1 cycle (no delay slot), 1 cycle after ds_valid (delay slot).
REQ-028 Back-to-back: br_valid in IDLE the cycle after a REDIR handshake completes is accepted.

Reset
REQ-029 rst_n low: state IDLE; redir_valid, flush, pr_we, slot_illegal, busy = 0; redir_pc, pr_wdata = 32'h0; immediate, any state.
REQ-030 Reset mid-DS_WAIT/REDIR discards pending target; no redirect after release.

Configuration
REQ-031 Macro PC_REDIRECT_PERF_EN: when defined, adds output perf_taken_cnt [31:0], incremented once per completed redirect handshake, wrapping at 2^32, reset to 0.
REQ-032 Macro undefined: port and counter absent; all other behaviour identical.

Structure
REQ-033 Shared package/defines: state encoding constants, PR return offset (4), reset address constant.
REQ-034 Single module, no sub-modules; optional counter inline under the macro.

Verification
REQ-035 BRA-like: br_valid, taken, delayslot, target 0x8C001000; ds_valid 2 cycles later, fetch_ready=1 -> flush pulse and redir_valid/redir_pc=0x8C001000 cycle after ds_valid, IDLE after.
REQ-036 BSR: br_pc=0x8C000010, write_pr, taken, delayslot -> pr_we next cycle, pr_wdata=0x8C000014; redirect after ds_valid.
REQ-037 Non-delayslot taken, fetch_ready low 3 cycles -> redir_valid/redir_pc held 3 cycles, flush only first cycle, single completion.
REQ-038 Delay slot is branch: ds_valid & ds_branch -> slot_illegal pulse, no redir_valid, no flush, busy drops.
REQ-039 rst_n low during REDIR -> outputs 0 immediately, no redirect after release; br_pc=0xFFFFFFFC with write_pr -> pr_wdata=0x00000000.
REQ-040 PERF_EN build: 5 completed redirects plus 2 not-taken -> perf_taken_cnt=5.
